// File: rtl/fo_sweep_pkg.sv
// Shared types and defaults for the Fo sweep sequencer.
package fo_sweep_pkg;

    localparam int FO_W           = 9;
    localparam int FO_MAX_DEFAULT = 400;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_LOOP   = 2'd1,
        MODE_UPDOWN = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DWELL     = 2'd1,
        ST_WAIT_WRAP = 2'd2,
        ST_FINISH    = 2'd3
    } state_e;

endpackage

// File: rtl/fo_step_calc.sv
// Next-Fo computation for one sweep step, with clamping to the start/stop window.
module fo_step_calc
    import fo_sweep_pkg::*;
#(
    parameter int W = FO_W
) (
    input  logic [W-1:0] fo,
    input  logic         dir_down,
    input  logic [W-1:0] start,
    input  logic [W-1:0] stop,
    input  logic [W-1:0] inc,
    input  mode_e        mode,
    output logic [W-1:0] next_fo,
    output logic         next_dir_down,
    output logic         at_end_single
);

    logic [W:0]        sum;
    logic signed [W:0] diff;
    logic [W-1:0]      up_fo;
    logic [W-1:0]      dn_fo;

    always_comb begin
        // One extra bit on both sides so the clamps never see a wrapped value.
        sum   = {1'b0, fo} + {1'b0, inc};
        diff  = $signed({1'b0, fo}) - $signed({1'b0, inc});
        up_fo = (sum > {1'b0, stop}) ? stop : sum[W-1:0];
        dn_fo = (diff < $signed({1'b0, start})) ? start : diff[W-1:0];

        next_fo       = fo;
        next_dir_down = dir_down;
        at_end_single = 1'b0;

        if (!dir_down) begin
            if (fo != stop) begin
                next_fo = up_fo;
            end else begin
                case (mode)
                    MODE_LOOP:   next_fo = start;
                    MODE_UPDOWN: begin
                        next_fo       = dn_fo;
                        next_dir_down = 1'b1;
                    end
                    default:     at_end_single = 1'b1;
                endcase
            end
        end else begin
            if (fo != start) begin
                next_fo = dn_fo;
            end else begin
                next_fo       = up_fo;
                next_dir_down = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fo_sweep_controller.sv
// Steps the generator Fo through a programmed sweep profile, optionally aligned to table wrap.
//   state        | meaning
//   ST_IDLE      | no sweep; config writable; fo/gen_run keep last value
//   ST_DWELL     | holding fo while the dwell counter runs down
//   ST_WAIT_WRAP | dwell expired, next fo held back until period_wrap
//   ST_FINISH    | single-up sweep reached stop; one-cycle done
module fo_sweep_controller
    import fo_sweep_pkg::*;
#(
    parameter int FO_W       = fo_sweep_pkg::FO_W,
    parameter int DWELL_W    = 16,
    parameter int FO_MAX     = FO_MAX_DEFAULT,
    parameter int PHASE_SYNC = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [FO_W-1:0]    cfg_fo_start,
    input  logic [FO_W-1:0]    cfg_fo_stop,
    input  logic [FO_W-1:0]    cfg_fo_inc,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    input  logic               start,
    input  logic               abort,
    input  logic               period_wrap,
    output logic [FO_W-1:0]    fo,
    output logic               gen_run,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    localparam logic [FO_W:0] FO_MAX_L = (FO_W+1)'(FO_MAX);
    localparam bit            SYNC_EN  = (PHASE_SYNC != 0);

    state_e               state_q, state_d;
    logic [FO_W-1:0]      fo_q, fo_d;
    logic                 dir_q, dir_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic                 gen_run_q, gen_run_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 cfg_vld_q, cfg_vld_d;
    logic [FO_W-1:0]      cfg_start_q, cfg_start_d;
    logic [FO_W-1:0]      cfg_stop_q, cfg_stop_d;
    logic [FO_W-1:0]      cfg_inc_q, cfg_inc_d;
    logic [DWELL_W-1:0]   cfg_dwell_q, cfg_dwell_d;
    mode_e                cfg_mode_q, cfg_mode_d;

    logic [FO_W-1:0]      step_fo;
    logic                 step_dir;
    logic                 step_end;
    logic [DWELL_W-1:0]   dwell_load;
    logic                 cfg_legal;

    fo_step_calc #(.W(FO_W)) u_step (
        .fo            (fo_q),
        .dir_down      (dir_q),
        .start         (cfg_start_q),
        .stop          (cfg_stop_q),
        .inc           (cfg_inc_q),
        .mode          (cfg_mode_q),
        .next_fo       (step_fo),
        .next_dir_down (step_dir),
        .at_end_single (step_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            fo_q        <= '0;
            dir_q       <= 1'b0;
            cnt_q       <= '0;
            gen_run_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
            cfg_vld_q   <= 1'b0;
            cfg_start_q <= '0;
            cfg_stop_q  <= '0;
            cfg_inc_q   <= '0;
            cfg_dwell_q <= '0;
            cfg_mode_q  <= MODE_SINGLE;
        end else begin
            state_q     <= state_d;
            fo_q        <= fo_d;
            dir_q       <= dir_d;
            cnt_q       <= cnt_d;
            gen_run_q   <= gen_run_d;
            cfg_err_q   <= cfg_err_d;
            cfg_vld_q   <= cfg_vld_d;
            cfg_start_q <= cfg_start_d;
            cfg_stop_q  <= cfg_stop_d;
            cfg_inc_q   <= cfg_inc_d;
            cfg_dwell_q <= cfg_dwell_d;
            cfg_mode_q  <= cfg_mode_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fo_d        = fo_q;
        dir_d       = dir_q;
        cnt_d       = cnt_q;
        gen_run_d   = gen_run_q;
        cfg_err_d   = cfg_err_q;
        cfg_vld_d   = cfg_vld_q;
        cfg_start_d = cfg_start_q;
        cfg_stop_d  = cfg_stop_q;
        cfg_inc_d   = cfg_inc_q;
        cfg_dwell_d = cfg_dwell_q;
        cfg_mode_d  = cfg_mode_q;

        dwell_load = (cfg_dwell_q == '0) ? '0 : cfg_dwell_q - DWELL_W'(1);
        cfg_legal  = (cfg_fo_start != '0) && (cfg_fo_start <= cfg_fo_stop) &&
                     ({1'b0, cfg_fo_stop} <= FO_MAX_L) && (cfg_fo_inc != '0) &&
                     (cfg_mode != MODE_RSVD);

        if (cfg_valid && state_q == ST_IDLE) begin
            if (cfg_legal) begin
                cfg_vld_d   = 1'b1;
                cfg_err_d   = 1'b0;
                cfg_start_d = cfg_fo_start;
                cfg_stop_d  = cfg_fo_stop;
                cfg_inc_d   = cfg_fo_inc;
                cfg_dwell_d = cfg_dwell;
                cfg_mode_d  = mode_e'(cfg_mode);
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        if (abort) begin
            state_d   = ST_IDLE;
            fo_d      = '0;
            gen_run_d = 1'b0;
            dir_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && cfg_vld_q) begin
                        fo_d      = cfg_start_q;
                        dir_d     = 1'b0;
                        gen_run_d = 1'b1;
                        cnt_d     = dwell_load;
                        state_d   = ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else if (step_end) begin
                        state_d = ST_FINISH;
                    end else if (!SYNC_EN || period_wrap) begin
                        fo_d  = step_fo;
                        dir_d = step_dir;
                        cnt_d = dwell_load;
                    end else begin
                        state_d = ST_WAIT_WRAP;
                    end
                end
                ST_WAIT_WRAP: begin
                    if (period_wrap) begin
                        fo_d    = step_fo;
                        dir_d   = step_dir;
                        cnt_d   = dwell_load;
                        state_d = ST_DWELL;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_ready = (state_q == ST_IDLE);
        busy      = (state_q == ST_DWELL) || (state_q == ST_WAIT_WRAP);
        done      = (state_q == ST_FINISH);
        fo        = fo_q;
        gen_run   = gen_run_q;
        cfg_err   = cfg_err_q;
    end

endmodule

// File: tb/tb_fo_sweep_controller.sv
// Directed bench: two controllers (immediate and wrap-aligned) checked against a sweep model.
module tb_fo_sweep_controller;

    logic        clk = 1'b0;
    logic        reset, cfg_valid, start, abort, period_wrap;
    logic [8:0]  cfg_fo_start, cfg_fo_stop, cfg_fo_inc;
    logic [15:0] cfg_dwell;
    logic [1:0]  cfg_mode;

    logic [8:0]  fo_o   [2];
    logic        gen_o  [2];
    logic        busy_o [2];
    logic        done_o [2];
    logic        err_o  [2];
    logic        rdy_o  [2];

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    fo_sweep_controller #(.FO_W(9), .DWELL_W(16), .FO_MAX(400), .PHASE_SYNC(0)) dut0 (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(rdy_o[0]),
        .cfg_fo_start(cfg_fo_start), .cfg_fo_stop(cfg_fo_stop), .cfg_fo_inc(cfg_fo_inc),
        .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .start(start), .abort(abort),
        .period_wrap(period_wrap), .fo(fo_o[0]), .gen_run(gen_o[0]), .busy(busy_o[0]),
        .done(done_o[0]), .cfg_err(err_o[0])
    );

    fo_sweep_controller #(.FO_W(9), .DWELL_W(16), .FO_MAX(400), .PHASE_SYNC(1)) dut1 (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(rdy_o[1]),
        .cfg_fo_start(cfg_fo_start), .cfg_fo_stop(cfg_fo_stop), .cfg_fo_inc(cfg_fo_inc),
        .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .start(start), .abort(abort),
        .period_wrap(period_wrap), .fo(fo_o[1]), .gen_run(gen_o[1]), .busy(busy_o[1]),
        .done(done_o[1]), .cfg_err(err_o[1])
    );

    // Model: phase 0 idle, 1 sweeping, 2 waiting for wrap, 3 finishing
    int m_ph [2];
    int m_fo [2];
    int m_dn [2];
    int m_held [2];
    int m_gen [2];
    int m_err [2];
    int m_cv [2];
    int m_s [2];
    int m_e [2];
    int m_inc [2];
    int m_dw [2];
    int m_mode [2];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void next_step(input int fo, input int dn, input int s, input int e,
                                      input int inc, input int mode,
                                      output int nf, output int nd, output int fin);
        nf = fo; nd = dn; fin = 0;
        if (dn == 0) begin
            if (fo != e)         nf = (fo + inc > e) ? e : fo + inc;
            else if (mode == 0)  fin = 1;
            else if (mode == 1)  nf = s;
            else begin
                nd = 1;
                nf = (fo - inc < s) ? s : fo - inc;
            end
        end else if (fo != s) begin
            nf = (fo - inc < s) ? s : fo - inc;
        end else begin
            nd = 0;
            nf = (fo + inc > e) ? e : fo + inc;
        end
    endfunction

    task automatic model_step(input int i);
        int go, nf, nd, fin, dmax;
        if (reset) begin
            m_ph[i] = 0; m_fo[i] = 0; m_dn[i] = 0; m_gen[i] = 0;
            m_err[i] = 0; m_cv[i] = 0; m_held[i] = 0;
            return;
        end
        go = (m_ph[i] == 0 && start && m_cv[i] != 0) ? 1 : 0;
        // Sweep launch uses the profile stored before this edge.
        if (go != 0) begin
            m_fo[i] = m_s[i];
        end
        if (m_ph[i] == 0 && cfg_valid) begin
            if (cfg_fo_start != 0 && cfg_fo_start <= cfg_fo_stop && cfg_fo_stop <= 400 &&
                cfg_fo_inc != 0 && cfg_mode != 3) begin
                m_s[i] = int'(cfg_fo_start); m_e[i] = int'(cfg_fo_stop);
                m_inc[i] = int'(cfg_fo_inc); m_dw[i] = int'(cfg_dwell);
                m_mode[i] = int'(cfg_mode); m_cv[i] = 1; m_err[i] = 0;
            end else begin
                m_err[i] = 1;
            end
        end
        if (abort) begin
            m_ph[i] = 0; m_fo[i] = 0; m_gen[i] = 0; m_dn[i] = 0;
            return;
        end
        dmax = (m_dw[i] < 1) ? 1 : m_dw[i];
        case (m_ph[i])
            0: if (go != 0) begin
                m_gen[i] = 1; m_dn[i] = 0; m_held[i] = 1; m_ph[i] = 1;
            end
            1: begin
                if (m_held[i] < dmax) m_held[i]++;
                else begin
                    next_step(m_fo[i], m_dn[i], m_s[i], m_e[i], m_inc[i], m_mode[i], nf, nd, fin);
                    if (fin != 0) m_ph[i] = 3;
                    else if (i == 0 || period_wrap) begin
                        m_fo[i] = nf; m_dn[i] = nd; m_held[i] = 1;
                    end else m_ph[i] = 2;
                end
            end
            2: if (period_wrap) begin
                next_step(m_fo[i], m_dn[i], m_s[i], m_e[i], m_inc[i], m_mode[i], nf, nd, fin);
                m_fo[i] = nf; m_dn[i] = nd; m_held[i] = 1; m_ph[i] = 1;
            end
            default: m_ph[i] = 0;
        endcase
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("dut%0d_fo", i), int'(fo_o[i]), m_fo[i]);
                check($sformatf("dut%0d_gen_run", i), int'(gen_o[i]), m_gen[i]);
                check($sformatf("dut%0d_busy", i), int'(busy_o[i]), (m_ph[i] == 1 || m_ph[i] == 2) ? 1 : 0);
                check($sformatf("dut%0d_done", i), int'(done_o[i]), (m_ph[i] == 3) ? 1 : 0);
                check($sformatf("dut%0d_cfg_ready", i), int'(rdy_o[i]), (m_ph[i] == 0) ? 1 : 0);
                check($sformatf("dut%0d_cfg_err", i), int'(err_o[i]), m_err[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input int s, input int e, input int inc, input int dw, input int mode);
        cfg_fo_start = 9'(s); cfg_fo_stop = 9'(e); cfg_fo_inc = 9'(inc);
        cfg_dwell = 16'(dw); cfg_mode = 2'(mode);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        int ud [7];
        int lp [5];
        ud = '{10, 20, 25, 15, 10, 20, 25};
        lp = '{10, 20, 25, 10, 20};
        reset = 1'b1; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0; period_wrap = 1'b0;
        cfg_fo_start = '0; cfg_fo_stop = '0; cfg_fo_inc = '0; cfg_dwell = '0; cfg_mode = '0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_ready", int'(rdy_o[0]), 1);
        check("rst_fo", int'(fo_o[0]), 0);
        reset = 1'b0;
        tick();

        // Single-up, dwell 4, immediate stepping
        write_cfg(10, 30, 10, 4, 0);
        go();
        check("single_fo_t1", int'(fo_o[0]), 10);
        repeat (4) tick();
        check("single_fo_t5", int'(fo_o[0]), 20);
        repeat (4) tick();
        check("single_fo_t9", int'(fo_o[0]), 30);
        repeat (4) tick();
        check("single_done_t13", int'(done_o[0]), 1);
        check("single_busy_t13", int'(busy_o[0]), 0);
        tick();
        check("single_fo_after", int'(fo_o[0]), 30);
        check("single_gen_after", int'(gen_o[0]), 1);
        do_abort();

        // Up/down and loop, dwell 1
        write_cfg(10, 25, 10, 1, 2);
        go();
        for (int k = 0; k < 7; k++) begin
            check($sformatf("updown_fo_%0d", k), int'(fo_o[0]), ud[k]);
            tick();
        end
        check("updown_busy", int'(busy_o[0]), 1);
        do_abort();
        write_cfg(10, 25, 10, 1, 1);
        go();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("loop_fo_%0d", k), int'(fo_o[0]), lp[k]);
            tick();
        end
        check("loop_busy", int'(busy_o[0]), 1);
        do_abort();

        // Wrap-aligned stepping, dwell 2
        write_cfg(10, 30, 10, 2, 1);
        go();
        repeat (6) tick();
        period_wrap = 1'b1;
        check("sync_hold_fo", int'(fo_o[1]), 10);
        check("sync_hold_busy", int'(busy_o[1]), 1);
        tick();
        period_wrap = 1'b0;
        check("sync_after_wrap", int'(fo_o[1]), 20);
        tick();
        period_wrap = 1'b1;
        check("sync_coinc_before", int'(fo_o[1]), 20);
        tick();
        period_wrap = 1'b0;
        check("sync_coinc_after", int'(fo_o[1]), 30);
        do_abort();

        // Illegal configs with nothing stored
        reset = 1'b1;
        tick();
        reset = 1'b0;
        write_cfg(50, 40, 10, 1, 0);
        check("bad_order_err", int'(err_o[0]), 1);
        go();
        check("bad_order_nostart", int'(busy_o[0]), 0);
        write_cfg(10, 20, 0, 1, 0);
        check("bad_inc_err", int'(err_o[0]), 1);
        write_cfg(10, 401, 10, 1, 0);
        check("bad_stop_err", int'(err_o[0]), 1);
        write_cfg(10, 20, 10, 1, 3);
        check("bad_mode_err", int'(err_o[0]), 1);
        go();
        check("bad_nostart", int'(gen_o[0]), 0);
        write_cfg(10, 20, 10, 2, 0);
        check("good_clears_err", int'(err_o[0]), 0);
        write_cfg(50, 40, 10, 1, 0);
        check("bad_after_good_err", int'(err_o[0]), 1);
        go();
        check("kept_cfg_busy", int'(busy_o[0]), 1);
        check("kept_cfg_fo", int'(fo_o[0]), 10);
        do_abort();

        // abort and start together mid-sweep
        write_cfg(10, 30, 10, 4, 1);
        go();
        repeat (4) tick();
        check("abort_pre_fo", int'(fo_o[0]), 20);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_fo", int'(fo_o[0]), 0);
        check("abort_gen", int'(gen_o[0]), 0);
        check("abort_busy", int'(busy_o[0]), 0);
        check("abort_done", int'(done_o[0]), 0);

        // reset mid-sweep clears the stored profile
        go();
        repeat (3) tick();
        check("rst_pre_busy", int'(busy_o[0]), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_fo", int'(fo_o[0]), 0);
        check("rst_mid_gen", int'(gen_o[0]), 0);
        check("rst_mid_busy", int'(busy_o[0]), 0);
        check("rst_mid_ready", int'(rdy_o[0]), 1);
        go();
        check("rst_nostart", int'(busy_o[0]), 0);
        tick();
        check("rst_nostart_gen", int'(gen_o[0]), 0);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
